// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point divider.
//   state_t     : handshake/datapath FSM states
//   bias()      : IEEE exponent bias for a given exponent width
//   canon_nan() : canonical quiet NaN bit pattern (zero-extended to 64 bits)
//   FLAG_*      : bit positions inside the 5-bit flags word
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam int FLAG_NV = 4;  // invalid
  localparam int FLAG_DZ = 3;  // divide by zero
  localparam int FLAG_OF = 2;  // overflow
  localparam int FLAG_UF = 1;  // underflow
  localparam int FLAG_NX = 0;  // inexact

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set, remaining bits clear.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mant_div_iter.sv
// Radix-2 restoring mantissa divider, one quotient bit per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor and begin MAN_W+3 iterations
//   dividend  : normalised dividend, divisor <= dividend < 2*divisor
//   divisor   : divisor significand with hidden bit
//   done      : high during the cycle performing the final iteration
//   quotient  : MAN_W+1 significant bits followed by guard and round
//   sticky    : final remainder is nonzero
module fp_mant_div_iter
  import fp_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W+1:0] dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             done,
  output logic [MAN_W+2:0] quotient,
  output logic             sticky
);

  localparam int CW = $clog2(MAN_W + 4);
  localparam logic [CW-1:0] LAST = CW'(MAN_W + 2);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [MAN_W+1:0] rem;
  logic [MAN_W+1:0] rem_sel;
  logic             ge;

  // rem stays below 2*divisor, so MAN_W+2 bits never overflow after the shift.
  always_comb begin
    ge      = rem >= {1'b0, divisor};
    rem_sel = ge ? (rem - {1'b0, divisor}) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      rem      <= dividend;
      quotient <= '0;
    end else if (busy) begin
      rem      <= rem_sel << 1;
      quotient <= {quotient[MAN_W+1:0], ge};
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done   = busy && (cnt == LAST);
  assign sticky = |rem;

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider with valid/ready handshake and RNE rounding.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only when idle)
//   a, b                 : dividend and divisor, XLEN = 1+EXP_W+MAN_W bits
//   out_valid / out_ready: result handshake; result/flags held until taken
//   result               : quotient
//   flags                : {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);

  localparam int XLEN = 1 + EXP_W + MAN_W;
  localparam logic [XLEN-1:0]      QNAN  = XLEN'(canon_nan(EXP_W, MAN_W));
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO = '0;

  state_t state, state_next;

  logic [XLEN-1:0]          a_q, b_q;
  logic                     sign_q;
  logic signed [EXP_W+1:0]  e_q;

  // Unpack / special-case signals
  logic                     sa, sb, sign;
  logic [EXP_W-1:0]         ea, eb;
  logic [MAN_W-1:0]         fa, fb;
  logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                     spec_hit;
  logic [XLEN-1:0]          spec_res;
  logic [4:0]               spec_flags;
  logic [MAN_W:0]           ma, mb;
  logic                     pre_shift;
  logic [MAN_W+1:0]         dividend;
  logic signed [EXP_W+1:0]  e_unp;

  // Mantissa divider interface
  logic                     mdiv_start;
  logic                     mdiv_done;
  logic [MAN_W+2:0]         quot;
  logic                     sticky;

  // Rounding signals
  logic [MAN_W:0]           mant;
  logic                     guard, rnd, round_up, nx;
  logic [MAN_W+1:0]         mant_r;
  logic [MAN_W-1:0]         frac;
  logic signed [EXP_W+1:0]  e_r;
  logic [XLEN-1:0]          round_res;
  logic [4:0]               round_flags;

  always_comb begin
    sa = a_q[XLEN-1];
    sb = b_q[XLEN-1];
    ea = a_q[XLEN-2:MAN_W];
    eb = b_q[XLEN-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    sign = sa ^ sb;

    // exp==0 covers both zero and subnormal, which are flushed to zero
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);

    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res            = QNAN;
      spec_flags[FLAG_NV] = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags[FLAG_DZ] = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_res = {sign, {(XLEN-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end

    // Pre-normalise so the quotient's leading bit is always 1.
    ma        = {1'b1, fa};
    mb        = {1'b1, fb};
    pre_shift = ma < mb;
    dividend  = pre_shift ? {ma, 1'b0} : {1'b0, ma};
    e_unp     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
    if (pre_shift) begin
      e_unp = e_unp - ONE;
    end
  end

  fp_mant_div_iter #(
    .MAN_W(MAN_W)
  ) u_mant_div (
    .clk      (clk),
    .rst      (rst),
    .start    (mdiv_start),
    .dividend (dividend),
    .divisor  (mb),
    .done     (mdiv_done),
    .quotient (quot),
    .sticky   (sticky)
  );

  always_comb begin
    mant     = quot[MAN_W+2:2];
    guard    = quot[1];
    rnd      = quot[0];
    nx       = guard | rnd | sticky;
    round_up = guard & (rnd | sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_W+2)'(round_up);
    // Carry-out leaves 10.00..0: fraction is the shifted-down field, exponent +1.
    if (mant_r[MAN_W+1]) begin
      frac = mant_r[MAN_W:1];
      e_r  = e_q + ONE;
    end else begin
      frac = mant_r[MAN_W-1:0];
      e_r  = e_q;
    end

    round_flags = '0;
    if (e_r >= EMAX) begin
      round_res            = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags[FLAG_OF] = 1'b1;
      round_flags[FLAG_NX] = 1'b1;
    end else if (e_r <= ZERO) begin
      round_res            = {sign_q, {(XLEN-1){1'b0}}};
      round_flags[FLAG_UF] = 1'b1;
      round_flags[FLAG_NX] = 1'b1;
    end else begin
      round_res            = {sign_q, e_r[EXP_W-1:0], frac};
      round_flags[FLAG_NX] = nx;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (in_valid) state_next = ST_UNPACK;
      ST_UNPACK: state_next = spec_hit ? ST_DONE : ST_DIV;
      ST_DIV:    if (mdiv_done) state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_DONE;
      ST_DONE:   if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_valid  = (state == ST_DONE);
    mdiv_start = (state == ST_UNPACK) && !spec_hit;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      e_q    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == ST_UNPACK) begin
        sign_q <= sign;
        e_q    <= e_unp;
        if (spec_hit) begin
          result <= spec_res;
          flags  <= spec_flags;
        end
      end
      if (state == ST_ROUND) begin
        result <= round_res;
        flags  <= round_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;

  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic        h_out_valid;
  logic        h_out_ready = 1'b0;
  logic [15:0] h_result;
  logic [4:0]  h_flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fp_div_iter #(
    .EXP_W(5),
    .MAN_W(10)
  ) dut_h (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .a         (h_a),
    .b         (h_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .result    (h_result),
    .flags     (h_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one operation, then return at the negedge of the first cycle with
  // out_valid high. lat is the cycle index relative to acceptance (T0).
  task automatic do_op(input bit half, input logic [31:0] av, input logic [31:0] bv,
                       input bit rdy, output logic [31:0] res, output logic [4:0] fl,
                       output int lat);
    @(negedge clk);
    if (half) begin
      h_in_valid = 1'b1; h_a = av[15:0]; h_b = bv[15:0]; h_out_ready = rdy;
    end else begin
      in_valid = 1'b1; a = av; b = bv; out_ready = rdy;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    lat = 1;
    while ((half ? h_out_valid : out_valid) !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = half ? {16'h0, h_result} : result;
    fl  = half ? h_flags : flags;
    if (rdy) @(negedge clk);
  endtask

  logic [31:0] res;
  logic [4:0]  fl;
  int          lat;
  bit          seen_ov;

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {27'h0, flags}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 6.0 / 2.0
    do_op(0, 32'h40C00000, 32'h40000000, 1, res, fl, lat);
    check("div6_2_res", res, 32'h40400000);
    check("div6_2_flags", {27'h0, fl}, 32'h0);
    check("div6_2_lat", lat, 32'd29);

    // 1.0 / 3.0, rounds up
    do_op(0, 32'h3F800000, 32'h40400000, 1, res, fl, lat);
    check("div1_3_res", res, 32'h3EAAAAAB);
    check("div1_3_flags", {27'h0, fl}, 32'h1);

    // 1.0 / +0
    do_op(0, 32'h3F800000, 32'h00000000, 1, res, fl, lat);
    check("dz_res", res, 32'h7F800000);
    check("dz_flags", {27'h0, fl}, 32'h08);
    check("dz_lat", lat, 32'd2);

    // 0 / 0
    do_op(0, 32'h00000000, 32'h00000000, 1, res, fl, lat);
    check("nan_res", res, 32'h7FC00000);
    check("nan_flags", {27'h0, fl}, 32'h10);
    check("nan_lat", lat, 32'd2);

    // Overflow
    do_op(0, 32'h7F7FFFFF, 32'h3F000000, 1, res, fl, lat);
    check("of_res", res, 32'h7F800000);
    check("of_flags", {27'h0, fl}, 32'h05);

    // Underflow
    do_op(0, 32'h00800000, 32'h40000000, 1, res, fl, lat);
    check("uf_res", res, 32'h00000000);
    check("uf_flags", {27'h0, fl}, 32'h03);

    // Back-pressure: hold out_ready low, offer a new op meanwhile
    do_op(0, 32'h3F800000, 32'h40400000, 0, res, fl, lat);
    check("bp_res", res, 32'h3EAAAAAB);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h00000000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_res", result, 32'h3EAAAAAB);
      check("bp_hold_flags", {27'h0, flags}, 32'h1);
      check("bp_hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_hold_out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_after_in_ready", {31'h0, in_ready}, 32'h1);
    check("bp_after_out_valid", {31'h0, out_valid}, 32'h0);
    repeat (3) @(negedge clk);
    check("bp_ignored", {31'h0, out_valid}, 32'h0);
    do_op(0, 32'h40C00000, 32'h40000000, 1, res, fl, lat);
    check("bp_next_res", res, 32'h40400000);
    check("bp_next_lat", lat, 32'd29);

    // Reset in the middle of a divide (asserted during T10)
    @(negedge clk);
    in_valid = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    check("mid_rst_no_result", {31'h0, seen_ov}, 32'h0);
    check("mid_rst_idle", {31'h0, in_ready}, 32'h1);

    // Half precision: 6.0 / 2.0
    do_op(1, 32'h4600, 32'h4000, 1, res, fl, lat);
    check("h_div_res", res, 32'h4200);
    check("h_div_flags", {27'h0, fl}, 32'h0);
    check("h_div_lat", lat, 32'd16);

    // Half precision: 1.0 / +0
    do_op(1, 32'h3C00, 32'h0000, 1, res, fl, lat);
    check("h_dz_res", res, 32'h7C00);
    check("h_dz_flags", {27'h0, fl}, 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Iterative, handshaked IEEE-754 floating-point divider with parametrised exponent and mantissa widths. It computes `a / b` with a radix-2 restoring mantissa recurrence (one quotient bit per cycle), handles special operands, and rounds to nearest-even. It is the next-generation divider for the FP datapath and sits beside the FP multiplier and adder. Unlike the current unpipelined Newton-Raphson reciprocal path, it uses a valid/ready interface, reports exception flags, and targets any IEEE-style format.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored fraction width. Total word width is `XLEN = 1+EXP_W+MAN_W`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  divider idle and accepting.
- `a`  in  XLEN  dividend.
- `b`  in  XLEN  divisor.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  XLEN  quotient.
- `flags`  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- FSM states: IDLE, UNPACK, DIV, ROUND, DONE.
- IDLE: `in_ready`=1. When `in_valid`=1, capture `a` and `b`, then go to UNPACK.
- UNPACK:
  - Sign = sa^sb.
  - Subnormal inputs (exp=0) are flushed to zero.
  - Special-case priority: NaN operand, or 0/0, or inf/inf -> canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1. Else finite/0 -> signed inf, div_by_zero=1. Else inf/x -> signed inf. Else x/inf or 0/x -> signed zero. All specials go directly to DONE.
  - Normal case: go to DIV.
- Exponent: signed `EXP_W+2` bits, `e = ea - eb + bias`, with `bias = 2^(EXP_W-1)-1`. If `ma < mb` (hidden bits included), shift `ma` left by 1 and decrement `e`.
- DIV: restoring recurrence over `MAN_W+3` cycles, producing `MAN_W+1` significant bits plus guard and round bits. The nonzero final remainder becomes the sticky bit.
- ROUND:
  - Round to nearest-even. A mantissa carry-out shifts right and increments `e`.
  - If `e >= 2^EXP_W-1`: signed inf, overflow=1, inexact=1.
  - If `e <= 0`: signed zero, underflow=1, inexact=1 (flush, no subnormal output).
  - Otherwise inexact = guard|round|sticky.
- DONE: `out_valid`=1. `result` and `flags` are stable until `out_ready`=1, then return to IDLE.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0, state IDLE.
- Let acceptance happen in cycle T0.
  - Normal operands: UNPACK in T1, DIV in T2..T(MAN_W+4), ROUND in T(MAN_W+5), `out_valid` high from T(MAN_W+6). For the default widths that is T29.
  - Special operands: `out_valid` high from T2.
- Throughput: one operation in flight. `in_ready`=0 from T1 until the cycle after the output handshake. No same-cycle in->out bypass.
- Back-pressure: DONE holds indefinitely. `result` and `flags` must not change while `out_valid`=1 and `out_ready`=0.
- `in_valid` while busy is ignored; there is no queueing.
- Reset asserted mid-operation: the operation is abandoned, outputs return to reset values immediately, and no result is emitted.

## Structure
- Shared package `fp_pkg`: FSM state enum, `bias(EXP_W)` function, canonical-NaN constant function, flag bit indices.
- Sub-module `fp_mant_div_iter`: the restoring mantissa divider with start/done strobes, an iteration counter of width `$clog2(MAN_W+4)`, and quotient/sticky outputs.
- Top level: unpack, special-case logic, exponent arithmetic, rounding, handshake FSM.

## Test plan
- 6.0/2.0 (`a`=0x40C00000, `b`=0x40000000), `out_ready`=1 -> `result`=0x40400000, `flags`=0, `out_valid` first high at T29.
- 1.0/3.0 (0x3F800000, 0x40400000) -> `result`=0x3EAAAAAB, inexact=1 only.
- 1.0/+0 -> 0x7F800000 with div_by_zero=1. 0/0 -> 0x7FC00000 with invalid=1. Both have `out_valid` at T2.
- 0x7F7FFFFF/0x3F000000 -> 0x7F800000 with overflow and inexact. 0x00800000/0x40000000 -> 0x00000000 with underflow and inexact.
- `out_ready` held 0 for 10 cycles after `out_valid`: `result` stable, `in_ready`=0 throughout, a new `in_valid` is ignored; the next operation is accepted only after the handshake.
- `rst` pulsed at T10 of a divide -> `out_valid` stays 0 and `in_ready`=1 right after reset. Rerun with `EXP_W`=5, `MAN_W`=10 (half precision): 0x4600/0x4000 -> 0x4200 at T16.
